// File: rtl/fpu_norm_round.sv
// fpu_norm_round: normalize + round-to-nearest-even stage behind the FP32 adder.
// Define FPU_NORM_LZC_EN for single-cycle leading-zero-count normalization.
module fpu_norm_round #(
  parameter int MAN_BITS = 23,
  parameter int EXP_BITS = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_sign,
  input  logic [EXP_BITS+1:0]          i_exp,
  input  logic [MAN_BITS+1:0]          i_man,
  input  logic [2:0]                   i_grs,
  input  logic                         i_special,
  input  logic [EXP_BITS+MAN_BITS:0]   i_special_val,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [EXP_BITS+MAN_BITS:0]   o_result,
  output logic                         o_overflow,
  output logic                         o_underflow,
  output logic                         o_inexact
);

  localparam int EW   = EXP_BITS + 2;
  localparam int MW   = MAN_BITS + 2;
  localparam int RW   = EXP_BITS + MAN_BITS + 1;
  localparam int EMAX = (1 << EXP_BITS) - 1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t          state_q, state_d;
  logic            rdy_q, rdy_d;
  logic            sign_q, sign_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic [MW-1:0]   man_q, man_d;
  logic [2:0]      grs_q, grs_d;
  logic [RW-1:0]   res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            inx_q, inx_d;

  logic            accept;
  logic            in_zero;
  logic            carry;

  assign accept  = i_valid && rdy_q;
  assign in_zero = (i_man == '0) && (i_grs == 3'b000);
  assign carry   = man_q[MW-1];

`ifdef FPU_NORM_LZC_EN
  localparam int XW = MAN_BITS + 4;

  function automatic logic [EW-1:0] lzc(input logic [XW-1:0] v);
    logic found;
    lzc   = '0;
    found = 1'b0;
    for (int i = XW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc   = lzc + EW'(1);
      end
    end
  endfunction

  logic [XW-1:0] nv, fill, sh;
  logic [EW-1:0] lz, lim, k;

  // GRS bits shift in behind the mantissa; sticky keeps refilling the tail
  always_comb begin
    nv   = {man_q[MAN_BITS:0], grs_q};
    lz   = lzc(nv);
    lim  = (exp_q > EW'(1)) ? exp_q - EW'(1) : '0;
    k    = (lz < lim) ? lz : lim;
    fill = grs_q[0] ? ~({XW{1'b1}} << k) : '0;
    sh   = (nv << k) | fill;
  end
`else
  logic can_left;
  assign can_left = !man_q[MAN_BITS] && (exp_q > EW'(1));
`endif

  logic                inc;
  logic [MAN_BITS+1:0] rsum;
  logic                rcarry;
  logic [MAN_BITS:0]   rman;
  logic [EW-1:0]       rexp;
  logic                r_inx;

  always_comb begin
    inc    = grs_q[2] & (grs_q[1] | grs_q[0] | man_q[0]);
    rsum   = {1'b0, man_q[MAN_BITS:0]} + {{(MAN_BITS+1){1'b0}}, inc};
    rcarry = rsum[MAN_BITS+1];
    rman   = rcarry ? rsum[MAN_BITS+1:1] : rsum[MAN_BITS:0];
    rexp   = exp_q + {{(EW-1){1'b0}}, rcarry};
    r_inx  = |grs_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = (i_special || in_zero) ? DONE : NORM;
      end
      NORM: begin
`ifdef FPU_NORM_LZC_EN
        state_d = ROUND;
`else
        if (!carry && !can_left) state_d = ROUND;
`endif
      end
      ROUND: state_d = DONE;
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_valid     = (state_q == DONE);
    o_ready     = rdy_q;
    o_result    = res_q;
    o_overflow  = ovf_q;
    o_underflow = unf_q;
    o_inexact   = inx_q;
  end

  always_comb begin
    rdy_d  = (state_d == IDLE);
    sign_d = sign_q;
    exp_d  = exp_q;
    man_d  = man_q;
    grs_d  = grs_q;
    res_d  = res_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    inx_d  = inx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = i_sign;
          exp_d  = i_exp;
          man_d  = i_man;
          grs_d  = i_grs;
          if (i_special) begin
            res_d = i_special_val;
            ovf_d = 1'b0;
            unf_d = 1'b0;
            inx_d = 1'b0;
          end else if (in_zero) begin
            res_d = {i_sign, {(RW-1){1'b0}}};
            ovf_d = 1'b0;
            unf_d = 1'b0;
            inx_d = 1'b0;
          end
        end
      end
      NORM: begin
        if (carry) begin
          man_d = {1'b0, man_q[MW-1:1]};
          grs_d = {man_q[0], grs_q[2], grs_q[1] | grs_q[0]};
          exp_d = exp_q + EW'(1);
`ifdef FPU_NORM_LZC_EN
        end else begin
          man_d = {1'b0, sh[XW-1:3]};
          grs_d = sh[2:0];
          exp_d = exp_q - k;
        end
`else
        end else if (can_left) begin
          man_d = {man_q[MAN_BITS:0], grs_q[2]};
          grs_d = {grs_q[1], grs_q[0], grs_q[0]};
          exp_d = exp_q - EW'(1);
        end
`endif
      end
      ROUND: begin
        unf_d = 1'b0;
        if (rexp >= EW'(EMAX)) begin
          res_d = {sign_q, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else if (rexp == EW'(1) && !rman[MAN_BITS]) begin
          res_d = {sign_q, {EXP_BITS{1'b0}}, rman[MAN_BITS-1:0]};
          ovf_d = 1'b0;
          unf_d = r_inx;
          inx_d = r_inx;
        end else begin
          res_d = {sign_q, rexp[EXP_BITS-1:0], rman[MAN_BITS-1:0]};
          ovf_d = 1'b0;
          inx_d = r_inx;
        end
      end
      DONE: ;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rdy_q  <= 1'b0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      man_q  <= '0;
      grs_q  <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      inx_q  <= 1'b0;
    end else begin
      rdy_q  <= rdy_d;
      sign_q <= sign_d;
      exp_q  <= exp_d;
      man_q  <= man_d;
      grs_q  <= grs_d;
      res_q  <= res_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      inx_q  <= inx_d;
    end
  end

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round: scoreboard bench with an arithmetic reference model.
// Directed test-plan vectors, backpressure, mid-op reset, then random traffic.
module tb_fpu_norm_round;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sign = 1'b0;
  logic [9:0]  i_exp = '0;
  logic [24:0] i_man = '0;
  logic [2:0]  i_grs = '0;
  logic        i_special = 1'b0;
  logic [31:0] i_special_val = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic        o_overflow, o_underflow, o_inexact;

  always #5 clk = ~clk;

  fpu_norm_round dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_man(i_man), .i_grs(i_grs),
    .i_special(i_special), .i_special_val(i_special_val),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .o_inexact(o_inexact)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   bp_hold = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: value = {man,g,r,s}; normalize hidden bit to bit 26, then RNE.
  function automatic exp_t model(input logic sgn, input logic [9:0] ein,
                                 input logic [24:0] m, input logic [2:0] grs,
                                 input logic sp, input logic [31:0] spv,
                                 input int t);
    exp_t r;
    logic [63:0] w, q, rem;
    int ex, k, p, n;
    bit up, ix;
    r.flg = 3'b000;
    if (sp) begin
      r.res = spv;
      r.due = t + 1;
      return r;
    end
    if (m == 0 && grs == 0) begin
      r.res = {sgn, 31'b0};
      r.due = t + 1;
      return r;
    end
    w  = {39'b0, m, grs};
    ex = int'(ein);
    if (w[27]) begin
      w  = (w >> 1) | (w & 64'd1);
      ex = ex + 1;
      n  = 1;
    end else begin
      p = 0;
      for (int i = 0; i < 28; i++) if (w[i]) p = i;
      k = 26 - p;
      if (k > ex - 1) k = ex - 1;
      if (k < 0) k = 0;
      w  = (w << k) | (grs[0] ? ((64'd1 << k) - 64'd1) : 64'd0);
      ex = ex - k;
      n  = k;
    end
    q   = w >> 3;
    rem = w & 64'd7;
    up  = (rem > 4) || (rem == 4 && q[0]);
    ix  = (rem != 0);
    if (up) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      r.res = {sgn, 8'hFF, 23'b0};
      r.flg = 3'b101;
    end else if (ex == 1 && q < (64'd1 << 23)) begin
      r.res = {sgn, 8'h00, q[22:0]};
      r.flg = {1'b0, ix, ix};
    end else begin
      r.res = {sgn, ex[7:0], q[22:0]};
      r.flg = {1'b0, 1'b0, ix};
    end
`ifdef FPU_NORM_LZC_EN
    r.due = t + 3;
`else
    r.due = t + n + 3;
`endif
    return r;
  endfunction

  task automatic send(input logic sgn, input logic [9:0] e,
                      input logic [24:0] m, input logic [2:0] grs,
                      input logic sp, input logic [31:0] spv,
                      input bit track);
    int w = 0;
    @(negedge clk);
    while (!o_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got o_ready=0 want 1 (cycle %0d)", cyc);
      return;
    end
    i_sign        = sgn;
    i_exp         = e;
    i_man         = m;
    i_grs         = grs;
    i_special     = sp;
    i_special_val = spv;
    i_valid       = 1'b1;
    if (track) sbq.push_back(model(sgn, e, m, grs, sp, spv, cyc));
    @(negedge clk);
    i_valid       = 1'b0;
    i_man         = 25'($urandom);
    i_exp         = 10'($urandom);
    i_grs         = 3'($urandom);
    i_special     = 1'($urandom);
    i_special_val = $urandom;
  endtask

  always @(negedge clk) begin
    if (i_rst_n && o_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got result %0h want none", o_result);
        i_ready = 1'b1;
      end else begin
        cur = sbq[0];
        if (!seen) begin
          check("latency", 64'(cyc), 64'(cur.due));
          seen = 1'b1;
        end
        check("result", 64'(o_result), 64'(cur.res));
        check("flags", 64'({o_overflow, o_underflow, o_inexact}),
              64'(cur.flg));
        check("ready_busy", 64'(o_ready), 64'd0);
        if (bp_hold > 0) begin
          i_ready = 1'b0;
          bp_hold--;
        end else begin
          i_ready = ($urandom_range(0, 3) != 0);
        end
        if (i_ready) begin
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end else begin
      i_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
    end
  endtask

  initial begin
    logic [9:0]  e;
    logic [24:0] m;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    check("rst_flags", 64'({o_overflow, o_underflow, o_inexact}), 64'd0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(o_ready), 64'd1);

    send(0, 10'd127, 25'h1000000, 3'b000, 0, 32'h0, 1);
    send(0, 10'd30,  25'h0000001, 3'b000, 0, 32'h0, 1);
    send(0, 10'd127, 25'h0800001, 3'b100, 0, 32'h0, 1);
    send(0, 10'd127, 25'h0800000, 3'b100, 0, 32'h0, 1);
    send(0, 10'd254, 25'h1FFFFFF, 3'b100, 0, 32'h0, 1);
    send(0, 10'd1,   25'h0400000, 3'b000, 0, 32'h0, 1);
    send(0, 10'd5,   25'h0, 3'b000, 1, 32'h7FC00000, 1);
    send(1, 10'd50,  25'h0, 3'b000, 0, 32'h0, 1);
    send(0, 10'd1,   25'h0000003, 3'b110, 0, 32'h0, 1);
    send(1, 10'd1,   25'h07FFFFF, 3'b100, 0, 32'h0, 1);
    send(0, 10'd40,  25'h0, 3'b001, 0, 32'h0, 1);
    drain();

    bp_hold = 5;
    send(1, 10'd200, 25'h0C00001, 3'b011, 0, 32'h0, 1);
    drain();

    send(0, 10'd30, 25'h0000001, 3'b000, 0, 32'h0, 0);
    repeat (4) @(negedge clk);
    i_rst_n = 1'b0;
    @(negedge clk);
    check("midop_rst_valid", 64'(o_valid), 64'd0);
    check("midop_rst_ready", 64'(o_ready), 64'd0);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("midop_ready_after", 64'(o_ready), 64'd1);
    repeat (40) @(negedge clk);
    check("midop_no_result", 64'(o_valid), 64'd0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       e = 10'd1;
        1:       e = 10'($urandom_range(2, 30));
        2:       e = 10'($urandom_range(250, 260));
        3:       e = 10'($urandom_range(1, 1023));
        default: e = 10'($urandom_range(100, 160));
      endcase
      if ($urandom_range(0, 15) == 0) m = '0;
      else m = 25'($urandom) >> $urandom_range(0, 25);
      send(1'($urandom), e, m, 3'($urandom),
           ($urandom_range(0, 15) == 0), $urandom, 1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
